// File: rtl/aq_spsram_param_init.sv
// aq_spsram_param_init: parametrised single-port SRAM with a registered read port,
// active-low chip, global and per-lane write enables, and an init_done status.
// Optional feature macro AQ_SPSRAM_INIT_SWEEP_EN:
//   defined   -> zero-fill sweep of every entry after reset; init_done rises after DEPTH cycles
//   undefined -> no sweep; init_done rises on the first edge after reset release
// DATA_WIDTH must be a multiple of WE_WIDTH; lane i covers bits [i*G +: G].
module aq_spsram_param_init #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 88,
  parameter int WE_WIDTH   = 88
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int G     = DATA_WIDTH / WE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic                  init_done_q, init_done_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_wmask;
  logic [DATA_WIDTH-1:0] lane_mask;

  // External accesses are only honoured once the array is ready.
  logic acc_write, acc_read;
  assign acc_write = init_done_q && !CEN && !GWEN;
  assign acc_read  = init_done_q && !CEN &&  GWEN;

  // Expand the active-low per-lane enables into a per-bit write mask.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < WE_WIDTH; i++) begin
      lane_mask[i*G +: G] = {G{~WEN[i]}};
    end
  end

`ifdef AQ_SPSRAM_INIT_SWEEP_EN
  typedef enum logic {ST_INIT, ST_IDLE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;

  // Sweep FSM: walk every address once writing zero, then settle in IDLE.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        if (init_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          init_addr_d = init_addr_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sweep state register with synchronous reset.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Array write port: sweep writes take priority over (gated-off) external writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = A;
    mem_wdata = D;
    mem_wmask = lane_mask;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr_q;
      mem_wdata = '0;
      mem_wmask = '1;
    end else if (acc_write) begin
      mem_we    = 1'b1;
    end
  end
`else
  // Without the sweep the array is usable on the first edge after reset release.
  always_comb begin
    init_done_d = 1'b1;
  end

  // Array write port: external writes only.
  always_comb begin
    mem_we    = acc_write;
    mem_waddr = A;
    mem_wdata = D;
    mem_wmask = lane_mask;
  end
`endif

  // Registered read data: load on a read, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (acc_read) begin
      q_d = mem[A];
    end
  end

  // Output/status registers with synchronous reset.
  always_ff @(posedge forever_cpuclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!cpurst_b) begin
      q_q         <= '0;
      init_done_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage array: masked read-modify-write of the addressed entry.
  always_ff @(posedge forever_cpuclk) begin
    // NOTE: the array is deliberately not reset; clearing is done by the sweep
    // so the storage can map onto a plain RAM macro.
    if (cpurst_b && mem_we) begin
      mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end
  end

  assign Q         = q_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_aq_spsram_param_init.sv
// Self-checking bench for aq_spsram_param_init (ADDR_WIDTH=6, DATA_WIDTH=88,
// WE_WIDTH=11 so each lane is one byte). Adapts to AQ_SPSRAM_INIT_SWEEP_EN.
module tb_aq_spsram_param_init;

  localparam int AW = 6;
  localparam int DW = 88;
  localparam int WW = 11;

  localparam logic [DW-1:0] ONES  = {DW{1'b1}};
  localparam logic [DW-1:0] PA5   = {11{8'hA5}};
  localparam logic [DW-1:0] LOW0  = 88'hFFFFFFFFFFFFFFFFFFFF00;
  localparam logic [DW-1:0] PAT   = 88'hFF23456789ABCDEFFEDCBA;
  localparam logic [DW-1:0] PAT_T = 88'h0023456789ABCDEFFEDCBA;

  logic          clk;
  logic          rst_b;
  logic [AW-1:0] a;
  logic          cen;
  logic          gwen;
  logic [WW-1:0] wen;
  logic [DW-1:0] d;
  logic [DW-1:0] q;
  logic          init_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          cen;
    logic          gwen;
    logic [WW-1:0] wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_q;
  } vec_t;

  vec_t vecs [14];

  aq_spsram_param_init #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .WE_WIDTH  (WW)
  ) dut (
    .forever_cpuclk(clk),
    .cpurst_b      (rst_b),
    .A             (a),
    .CEN           (cen),
    .GWEN          (gwen),
    .WEN           (wen),
    .D             (d),
    .Q             (q),
    .init_done     (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic g, input logic [WW-1:0] w,
                       input logic [AW-1:0] ad, input logic [DW-1:0] dd);
    cen  = c;
    gwen = g;
    wen  = w;
    a    = ad;
    d    = dd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, '1, '0, '0);
  endtask

  // Hold reset for a few edges and check the reset state.
  task automatic do_reset(input string tag);
    rst_b = 1'b0;
    idle();
    repeat (3) step();
    check({tag, "_rst_q"}, q, '0);
    check({tag, "_rst_done"}, DW'(init_done), DW'(1'b0));
  endtask

  // Single read with one-cycle latency.
  task automatic read_check(input string name, input logic [AW-1:0] ad, input logic [DW-1:0] exp);
    drive(1'b0, 1'b1, '1, ad, '0);
    step();
    check(name, q, exp);
  endtask

`ifdef AQ_SPSRAM_INIT_SWEEP_EN
  // Run the full sweep: init_done must stay 0 for 63 edges and be 1 after the 64th.
  // An optional ignored write is driven just before edge wr_edge.
  task automatic sweep(input string tag, input int wr_edge);
    for (int k = 1; k <= 64; k++) begin
      if (k == wr_edge) drive(1'b0, 1'b0, '0, 6'd63, ONES);
      else idle();
      step();
      check({tag, "_sweep_done"}, DW'(init_done), DW'(k == 64));
      check({tag, "_sweep_q"}, q, '0);
    end
    idle();
  endtask
`endif

  initial begin
    rst_b = 1'b0;
    idle();

    // cen gwen wen a d exp_q
    vecs[0]  = '{1'b0, 1'b0, 11'h000, 6'd5,  PA5,  '0};
    vecs[1]  = '{1'b0, 1'b1, 11'h000, 6'd5,  '0,   PA5};
    vecs[2]  = '{1'b0, 1'b0, 11'h000, 6'd9,  ONES, PA5};
    vecs[3]  = '{1'b0, 1'b0, 11'h7FE, 6'd9,  '0,   PA5};
    vecs[4]  = '{1'b0, 1'b1, 11'h7FF, 6'd9,  '0,   LOW0};
    vecs[5]  = '{1'b1, 1'b0, 11'h000, 6'd5,  '0,   LOW0};
    vecs[6]  = '{1'b0, 1'b1, 11'h000, 6'd5,  '0,   PA5};
    vecs[7]  = '{1'b0, 1'b0, 11'h7FF, 6'd5,  '0,   PA5};
    vecs[8]  = '{1'b0, 1'b1, 11'h000, 6'd5,  '0,   PA5};
    vecs[9]  = '{1'b0, 1'b0, 11'h000, 6'd63, PAT,  PA5};
    vecs[10] = '{1'b0, 1'b1, 11'h000, 6'd63, '0,   PAT};
    vecs[11] = '{1'b0, 1'b1, 11'h000, 6'd9,  '0,   LOW0};
    vecs[12] = '{1'b0, 1'b0, 11'h3FF, 6'd63, '0,   LOW0};
    vecs[13] = '{1'b0, 1'b1, 11'h000, 6'd63, '0,   PAT_T};

    do_reset("por");
    rst_b = 1'b1;

`ifdef AQ_SPSRAM_INIT_SWEEP_EN
    // Full sweep with a write to 63 attempted at cycle 10 (must be ignored).
    sweep("por", 10);
    for (int i = 0; i < 64; i++) begin
      read_check($sformatf("zero_rd%0d", i), AW'(i), '0);
    end
`else
    drive(1'b0, 1'b0, '0, 6'd63, ONES);
    step();
    check("por_done_1cyc", DW'(init_done), DW'(1'b1));
    check("por_q", q, '0);
    idle();
`endif

    // Table-driven read/write vectors.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].cen, vecs[i].gwen, vecs[i].wen, vecs[i].a, vecs[i].d);
      step();
      check($sformatf("vec%0d", i), q, vecs[i].exp_q);
    end

    // Q holds across idle cycles, whatever the address/data lines do.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, '0, AW'(i), '0);
      step();
      check($sformatf("idle_hold%0d", i), q, PAT_T);
    end
    read_check("cen_hi_no_write", 6'd5, PA5);

`ifdef AQ_SPSRAM_INIT_SWEEP_EN
    // Reset again, abort the sweep at address 30, then a full sweep must restart at 0.
    do_reset("mid");
    rst_b = 1'b1;
    repeat (30) step();
    check("mid_not_done", DW'(init_done), DW'(1'b0));
    do_reset("mid2");
    rst_b = 1'b1;
    sweep("mid2", 0);
    read_check("mid_rd5",  6'd5,  '0);
    read_check("mid_rd9",  6'd9,  '0);
    read_check("mid_rd63", 6'd63, '0);
`else
    // Reset mid-operation: Q clears, contents survive, the first post-release
    // edge ignores a write, and init_done rises one edge after release.
    do_reset("mid");
    rst_b = 1'b1;
    drive(1'b0, 1'b0, '0, 6'd63, ONES);
    step();
    check("mid_done_1cyc", DW'(init_done), DW'(1'b1));
    check("mid_q", q, '0);
    read_check("mid_rd63", 6'd63, PAT_T);
    read_check("mid_rd5",  6'd5,  PA5);
    read_check("mid_rd9",  6'd9,  LOW0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
